// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on load, per-half C/D rotation each round,
// PC-2 to present one registered 48-bit subkey per consumer handshake.
module des_key_schedule #(
  parameter bit PARITY_CHECK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_ack,
  output logic [47:0] round_key,
  output logic        key_valid,
  output logic [4:0]  round_num,
  output logic        busy,
  output logic        done,
  output logic        key_err
);
  typedef enum logic {IDLE, RUN} state_t;

  // Table entries use DES numbering: bit 1 is the MSB of the source vector.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  state_t      state, state_nx;
  logic [55:0] cd, cd_nx, cd_load;
  logic        dec, dec_nx;
  logic [47:0] round_key_nx;
  logic [4:0]  round_num_nx;
  logic        key_valid_nx, busy_nx, done_nx, key_err_nx;
  logic        last, parity_ok;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] c);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = c[6'(56 - PC2_T[i])];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one; every other round by two.
  function automatic logic shift_two(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic odd_bytes(input logic [63:0] k);
    return (^k[63:56]) & (^k[55:48]) & (^k[47:40]) & (^k[39:32]) &
           (^k[31:24]) & (^k[23:16]) & (^k[15:8])  & (^k[7:0]);
  endfunction

  assign parity_ok = odd_bytes(key_in);
  assign last      = dec ? (round_num == 5'd1) : (round_num == 5'd16);

  // Decrypt starts at C16D16, which equals C0D0 because the shifts total 28.
  always_comb begin
    cd_load = pc1(key_in);
    if (!decrypt) cd_load = {rotl28(cd_load[55:28], 1'b0), rotl28(cd_load[27:0], 1'b0)};
  end

  always_comb begin
    state_nx     = state;
    cd_nx        = cd;
    dec_nx       = dec;
    round_key_nx = round_key;
    round_num_nx = round_num;
    key_valid_nx = key_valid;
    busy_nx      = busy;
    done_nx      = 1'b0;
    key_err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (PARITY_CHECK && !parity_ok) begin
            key_err_nx = 1'b1;
          end else begin
            cd_nx        = cd_load;
            dec_nx       = decrypt;
            round_key_nx = pc2(cd_load);
            round_num_nx = decrypt ? 5'd16 : 5'd1;
            key_valid_nx = 1'b1;
            busy_nx      = 1'b1;
            state_nx     = RUN;
          end
        end
      end
      RUN: begin
        if (key_ack && key_valid) begin
          if (last) begin
            key_valid_nx = 1'b0;
            busy_nx      = 1'b0;
            done_nx      = 1'b1;
            state_nx     = IDLE;
          end else if (dec) begin
            cd_nx        = {rotr28(cd[55:28], shift_two(round_num)),
                            rotr28(cd[27:0],  shift_two(round_num))};
            round_key_nx = pc2(cd_nx);
            round_num_nx = round_num - 5'd1;
          end else begin
            cd_nx        = {rotl28(cd[55:28], shift_two(round_num + 5'd1)),
                            rotl28(cd[27:0],  shift_two(round_num + 5'd1))};
            round_key_nx = pc2(cd_nx);
            round_num_nx = round_num + 5'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cd        <= '0;
      dec       <= 1'b0;
      round_key <= '0;
      round_num <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cd        <= cd_nx;
      dec       <= dec_nx;
      round_key <= round_key_nx;
      round_num <= round_num_nx;
      key_valid <= key_valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      key_err   <= key_err_nx;
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule; subkeys are predicted from cumulative
// rotation of C0/D0 in a bit-array reference model.
module tb_des_key_schedule;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, decrypt = 1'b0, key_ack = 1'b0;
  logic [63:0] key_in = '0;
  logic [47:0] round_key;
  logic [4:0]  round_num;
  logic        key_valid, busy, done, key_err;

  logic        p_start = 1'b0, p_dec = 1'b0, p_ack = 1'b0;
  logic [63:0] p_key = '0;
  logic [47:0] p_round_key;
  logic [4:0]  p_num;
  logic        p_valid, p_busy, p_done, p_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] ref_k [1:16];
  logic [47:0] seen [16];
  logic [47:0] seen_enc [16];

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .decrypt(decrypt),
    .key_ack(key_ack), .round_key(round_key), .key_valid(key_valid),
    .round_num(round_num), .busy(busy), .done(done), .key_err(key_err));

  des_key_schedule #(.PARITY_CHECK(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(p_start), .key_in(p_key), .decrypt(p_dec),
    .key_ack(p_ack), .round_key(p_round_key), .key_valid(p_valid),
    .round_num(p_num), .busy(p_busy), .done(p_done), .key_err(p_err));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Subkey r is PC-2 of C0/D0 rotated left by the running total of shifts.
  task automatic compute_ref(input logic [63:0] key);
    bit cd0 [56];
    bit rot [56];
    int tot;
    for (int i = 0; i < 56; i++) cd0[i] = key[6'(64 - PC1[i])];
    tot = 0;
    for (int r = 1; r <= 16; r++) begin
      tot += SHIFTS[r-1];
      for (int j = 0; j < 28; j++) begin
        rot[j]      = cd0[(j + tot) % 28];
        rot[28 + j] = cd0[28 + (j + tot) % 28];
      end
      for (int k = 0; k < 48; k++) ref_k[r][6'(47 - k)] = rot[PC2[k] - 1];
    end
  endtask

  task automatic do_start(input logic [63:0] key, input logic dec);
    @(negedge clk);
    key_in  = key;
    decrypt = dec;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // mode 0: ack always; 1: random ack with a 5-cycle stall at round 9;
  // 2: ack always while start/key_in/decrypt are scrambled every cycle.
  task automatic run_keys(input logic dec, input int mode, output int cyc);
    int idx, er, stall;
    logic ack;
    idx = 0; cyc = 0; stall = 0;
    while (idx < 16 && cyc < 400) begin
      er = dec ? 16 - idx : idx + 1;
      check_eq("key_valid", 64'(key_valid), 64'(1));
      check_eq("busy", 64'(busy), 64'(1));
      check_eq("round_key", 64'(round_key), 64'(ref_k[er]));
      check_eq("round_num", 64'(round_num), 64'(er));
      if (mode == 1) begin
        if (er == 9 && stall < 5) begin
          ack = 1'b0;
          stall++;
        end else begin
          ack = 1'($urandom_range(0, 1));
        end
      end else begin
        ack = 1'b1;
      end
      if (mode == 2) begin
        start   = 1'b1;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
      end
      if (ack) seen[idx] = round_key;
      key_ack = ack;
      @(negedge clk);
      cyc++;
      if (ack) idx++;
    end
    if (idx < 16) check_eq("schedule_timeout", 64'(idx), 64'(16));
    if (mode == 1) check_eq("stall_cycles", 64'(stall), 64'(5));
    start   = 1'b0;
    key_ack = 1'b0;
    check_eq("done_pulse", 64'(done), 64'(1));
    check_eq("valid_after", 64'(key_valid), 64'(0));
    check_eq("busy_after", 64'(busy), 64'(0));
    check_eq("key_hold", 64'(round_key), 64'(ref_k[dec ? 1 : 16]));
    check_eq("num_hold", 64'(round_num), 64'(dec ? 1 : 16));
  endtask

  initial begin
    int cyc;
    logic [63:0] k;
    logic d;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_round_key", 64'(round_key), 64'(0));
    check_eq("rst_round_num", 64'(round_num), 64'(0));
    check_eq("rst_valid", 64'(key_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_key_err", 64'(key_err), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known-answer encrypt with ack held high
    compute_ref(64'h133457799BBCDFF1);
    do_start(64'h133457799BBCDFF1, 1'b0);
    run_keys(1'b0, 0, cyc);
    check_eq("enc_cycles", 64'(cyc), 64'(16));
    check_eq("kat_k1", 64'(seen[0]), 64'h1B02EFFC7072);
    check_eq("kat_k16", 64'(seen[15]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) seen_enc[i] = seen[i];
    key_ack = 1'b1;
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    check_eq("idle_ack_valid", 64'(key_valid), 64'(0));
    check_eq("idle_ack_num", 64'(round_num), 64'(16));
    key_ack = 1'b0;

    // Known-answer decrypt
    do_start(64'h133457799BBCDFF1, 1'b1);
    run_keys(1'b1, 0, cyc);
    check_eq("kat_dec_first", 64'(seen[0]), 64'hCB3D8B0E17F5);
    check_eq("kat_dec_last", 64'(seen[15]), 64'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) check_eq("dec_reverse", 64'(seen[i]), 64'(seen_enc[15 - i]));

    // Back-pressure
    do_start(64'h133457799BBCDFF1, 1'b0);
    run_keys(1'b0, 1, cyc);

    // Reset in the middle of a schedule
    k = {$urandom, $urandom};
    compute_ref(k);
    do_start(k, 1'b0);
    key_ack = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_num", 64'(round_num), 64'(7));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_key", 64'(round_key), 64'(0));
    check_eq("mid_rst_num", 64'(round_num), 64'(0));
    check_eq("mid_rst_valid", 64'(key_valid), 64'(0));
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    key_ack = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    k = {$urandom, $urandom};
    compute_ref(k);
    do_start(k, 1'b0);
    run_keys(1'b0, 0, cyc);

    // start during RUN ignored, start on the done cycle accepted
    compute_ref(64'h0E329232EA6D0D73);
    do_start(64'h0E329232EA6D0D73, 1'b0);
    run_keys(1'b0, 2, cyc);
    k = {$urandom, $urandom};
    compute_ref(k);
    key_in  = k;
    decrypt = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    run_keys(1'b0, 0, cyc);

    // Parity rejection on the checking instance
    @(negedge clk);
    p_key   = 64'h133457799BBCDFF0;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    check_eq("par_err", 64'(p_err), 64'(1));
    check_eq("par_busy", 64'(p_busy), 64'(0));
    check_eq("par_valid", 64'(p_valid), 64'(0));
    check_eq("par_num", 64'(p_num), 64'(0));
    @(negedge clk);
    check_eq("par_err_pulse", 64'(p_err), 64'(0));
    compute_ref(64'h133457799BBCDFF1);
    p_key   = 64'h133457799BBCDFF1;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    check_eq("par_ok_err", 64'(p_err), 64'(0));
    check_eq("par_ok_busy", 64'(p_busy), 64'(1));
    p_ack = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      check_eq("par_key", 64'(p_round_key), 64'(ref_k[r]));
      check_eq("par_round", 64'(p_num), 64'(r));
      @(negedge clk);
    end
    p_ack = 1'b0;
    check_eq("par_done", 64'(p_done), 64'(1));

    // Random keys and directions under random back-pressure
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom};
      d = 1'($urandom_range(0, 1));
      compute_ref(k);
      do_start(k, d);
      run_keys(d, 1, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
